// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, issues word reads, and buffers words with their PCs for decode.
// Optional feature: define FETCH_FAULT_EN to trap misaligned redirect targets through fetch_fault.
module instruction_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        mem_request,
    output logic [31:0] mem_address,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
`ifdef FETCH_FAULT_EN
    ,
    output logic        fetch_fault
`endif
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {FETCH, STALL, FAULT} state_t;

    state_t             state_q, state_d;
    logic [31:0]        fetch_pc, pc_d;
    logic               req_d;
    logic [CNT_W-1:0]   count_q, cnt_d;
    logic [PTR_W-1:0]   rd_ptr, rd_d;
    logic [PTR_W-1:0]   wr_ptr, wr_d;
    logic               valid_d;
    logic [31:0]        head_word_d, head_pc_d;
    logic               do_push, do_pop;
    logic [31:0]        redirect_pc;
`ifdef FETCH_FAULT_EN
    logic               fault_d;
`endif

    logic [31:0]        word_q [FIFO_DEPTH];
    logic [31:0]        pcs_q  [FIFO_DEPTH];

    // The PC register is always word aligned, so it drives the memory address directly.
    assign mem_address = fetch_pc;

    // Next-state, FIFO bookkeeping and next head outputs; redirects take priority over push/pop.
    always_comb begin
        state_d     = state_q;
        pc_d        = fetch_pc;
        req_d       = mem_request;
        cnt_d       = count_q;
        rd_d        = rd_ptr;
        wr_d        = wr_ptr;
        valid_d     = instr_valid;
        head_word_d = instr;
        head_pc_d   = instr_pc;
        do_push     = 1'b0;
        do_pop      = 1'b0;
        redirect_pc = branch_target & 32'hFFFF_FFFC;
`ifdef FETCH_FAULT_EN
        fault_d     = fetch_fault;
`endif

        if (state_q == FAULT) begin
            req_d = 1'b0;
        end else if (branch_taken) begin
            cnt_d   = '0;
            rd_d    = '0;
            wr_d    = '0;
            pc_d    = redirect_pc;
            state_d = FETCH;
            req_d   = 1'b1;
`ifdef FETCH_FAULT_EN
            if (branch_target[1:0] != 2'b00) begin
                state_d = FAULT;
                req_d   = 1'b0;
                fault_d = 1'b1;
            end
`endif
        end else begin
            do_push = mem_request && mem_ready;
            do_pop  = (count_q != '0) && instr_ready;
            if (do_push) begin
                pc_d = fetch_pc + 32'd4;
                wr_d = wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_d = rd_ptr + PTR_W'(1);
            end
            cnt_d   = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
            state_d = (cnt_d == CNT_W'(FIFO_DEPTH)) ? STALL : FETCH;
            req_d   = (state_d == FETCH);
        end

        valid_d = (cnt_d != '0);
        // A word written this cycle into the slot that becomes head bypasses the array.
        if (valid_d) begin
            if (do_push && (wr_ptr == rd_d)) begin
                head_word_d = mem_rdata;
                head_pc_d   = fetch_pc;
            end else begin
                head_word_d = word_q[rd_d];
                head_pc_d   = pcs_q[rd_d];
            end
        end
    end

    // Control state, PC, pointers and registered head outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= FETCH;
            fetch_pc    <= RESET_VECTOR & 32'hFFFF_FFFC;
            mem_request <= 1'b0;
            count_q     <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
`ifdef FETCH_FAULT_EN
            fetch_fault <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            fetch_pc    <= pc_d;
            mem_request <= req_d;
            count_q     <= cnt_d;
            rd_ptr      <= rd_d;
            wr_ptr      <= wr_d;
            instr_valid <= valid_d;
            instr       <= head_word_d;
            instr_pc    <= head_pc_d;
`ifdef FETCH_FAULT_EN
            fetch_fault <= fault_d;
`endif
        end
    end

    // FIFO storage: instruction word and its PC per entry.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                word_q[i] <= '0;
                pcs_q[i]  <= '0;
            end
        end else if (do_push) begin
            word_q[wr_ptr] <= mem_rdata;
            pcs_q[wr_ptr]  <= fetch_pc;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch; define FETCH_FAULT_EN to also exercise the misaligned-redirect trap.
module tb_instruction_fetch;

    logic        clock;
    logic        reset_n;
    logic        mem_request;
    logic [31:0] mem_address;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
`ifdef FETCH_FAULT_EN
    logic        fetch_fault;
`endif

    int tests = 0;
    int fails = 0;

    instruction_fetch dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .mem_request   (mem_request),
        .mem_address   (mem_address),
        .mem_ready     (mem_ready),
        .mem_rdata     (mem_rdata),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_ready   (instr_ready)
`ifdef FETCH_FAULT_EN
        ,
        .fetch_fault   (fetch_fault)
`endif
    );

    // Instruction memory contents: fixed word at 0, address-derived pattern elsewhere.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0600_2103 : (a ^ 32'h5A5A_0000);
    endfunction

    assign mem_rdata = word_at(mem_address);

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n       = 1'b0;
        mem_ready     = 1'b0;
        instr_ready   = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_req",   32'(mem_request), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr,            32'h0);
        check("rst_pc",    instr_pc,         32'h0);
        check("rst_addr",  mem_address,      32'h0);

        // Streaming fetch, one word per cycle
        mem_ready   = 1'b1;
        instr_ready = 1'b1;
        @(negedge clock) reset_n = 1'b1;
        step();
        check("t1_req0",   32'(mem_request), 32'd1);
        check("t1_addr0",  mem_address,      32'h0);
        check("t1_valid0", 32'(instr_valid), 32'd0);
        step();
        check("t1_addr1",  mem_address,      32'h4);
        check("t1_valid1", 32'(instr_valid), 32'd1);
        check("t1_instr1", instr,            32'h0600_2103);
        check("t1_pc1",    instr_pc,         32'h0);
        step();
        check("t1_addr2",  mem_address,      32'h8);
        check("t1_pc2",    instr_pc,         32'h4);
        check("t1_instr2", instr,            32'h5A5A_0004);

        // Pending request held, then async reset mid-request
        mem_ready   = 1'b0;
        instr_ready = 1'b0;
        step();
        check("t4_req",    32'(mem_request), 32'd1);
        check("t4_addr",   mem_address,      32'h8);
        check("t4_valid",  32'(instr_valid), 32'd1);
        check("t4_pc",     instr_pc,         32'h4);
        step();
        check("t4_hold",   mem_address,      32'h8);
        check("t4_hold_pc", instr_pc,        32'h4);
        #2 reset_n = 1'b0;
        #1;
        check("t4_async_req",   32'(mem_request), 32'd0);
        check("t4_async_valid", 32'(instr_valid), 32'd0);
        check("t4_async_instr", instr,            32'h0);
        check("t4_async_addr",  mem_address,      32'h0);
        @(negedge clock) reset_n = 1'b1;
        step();
        check("t4_first_req",  32'(mem_request), 32'd1);
        check("t4_first_addr", mem_address,      32'h0);

        // Fill FIFO with no consumer, stall, resume on a single pop
        mem_ready = 1'b1;
        step();
        check("t2_addr4",  mem_address, 32'h4);
        check("t2_head0",  instr_pc,    32'h0);
        step();
        check("t2_addr8",  mem_address, 32'h8);
        step();
        check("t2_addrC",  mem_address, 32'hC);
        step();
        check("t2_full_req",   32'(mem_request), 32'd0);
        check("t2_full_valid", 32'(instr_valid), 32'd1);
        check("t2_full_pc",    instr_pc,         32'h0);
        step();
        check("t2_stall_req",  32'(mem_request), 32'd0);
        check("t2_stall_instr", instr,           32'h0600_2103);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        check("t2_resume_req",  32'(mem_request), 32'd1);
        check("t2_resume_addr", mem_address,      32'h10);
        check("t2_pop_pc",      instr_pc,         32'h4);
        step();
        check("t2_refull_req",  32'(mem_request), 32'd0);
        check("t2_refull_pc",   instr_pc,         32'h4);
        instr_ready = 1'b1;
        mem_ready   = 1'b0;
        step();
        check("t2_drain_pc8",   instr_pc,         32'h8);
        check("t2_drain_req",   32'(mem_request), 32'd1);
        check("t2_drain_addr",  mem_address,      32'h14);
        step();
        check("t2_drain_pcC",   instr_pc,         32'hC);
        step();
        check("t2_drain_pc10",  instr_pc,         32'h10);
        check("t2_drain_in10",  instr,            32'h5A5A_0010);
        step();
        check("t2_empty",       32'(instr_valid), 32'd0);

        // Redirect coinciding with completion of pc 0x8
        #2 reset_n = 1'b0;
        #1;
        mem_ready   = 1'b1;
        instr_ready = 1'b1;
        @(negedge clock) reset_n = 1'b1;
        step();
        step();
        step();
        check("t3_pre_addr", mem_address, 32'h8);
        check("t3_pre_pc",   instr_pc,    32'h4);
        branch_taken  = 1'b1;
        branch_target = 32'h100;
        step();
        branch_taken = 1'b0;
        check("t3_req",   32'(mem_request), 32'd1);
        check("t3_addr",  mem_address,      32'h100);
        check("t3_valid", 32'(instr_valid), 32'd0);
        step();
        check("t3_head_valid", 32'(instr_valid), 32'd1);
        check("t3_head_pc",    instr_pc,         32'h100);
        check("t3_head_instr", instr,            32'h5A5A_0100);
        check("t3_next_addr",  mem_address,      32'h104);

        // PC wrap at the top of the address space
        branch_taken  = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        step();
        branch_taken = 1'b0;
        check("t6_addr_top",  mem_address,      32'hFFFF_FFFC);
        check("t6_valid",     32'(instr_valid), 32'd0);
        step();
        check("t6_addr_wrap", mem_address,      32'h0);
        check("t6_pc_top",    instr_pc,         32'hFFFF_FFFC);
        step();
        check("t6_addr4",     mem_address,      32'h4);
        check("t6_pc0",       instr_pc,         32'h0);
        check("t6_instr0",    instr,            32'h0600_2103);

        // Misaligned redirect target
        branch_taken  = 1'b1;
        branch_target = 32'h102;
        step();
        branch_taken = 1'b0;
`ifdef FETCH_FAULT_EN
        check("t5_fault",  32'(fetch_fault), 32'd1);
        check("t5_req",    32'(mem_request), 32'd0);
        check("t5_valid",  32'(instr_valid), 32'd0);
        step();
        step();
        check("t5_sticky_fault", 32'(fetch_fault), 32'd1);
        check("t5_sticky_req",   32'(mem_request), 32'd0);
        check("t5_sticky_valid", 32'(instr_valid), 32'd0);
        #2 reset_n = 1'b0;
        #1;
        check("t5_rst_fault", 32'(fetch_fault), 32'd0);
        @(negedge clock) reset_n = 1'b1;
        step();
        check("t5_restart_req",  32'(mem_request), 32'd1);
        check("t5_restart_addr", mem_address,      32'h0);
`else
        check("t5_req",   32'(mem_request), 32'd1);
        check("t5_addr",  mem_address,      32'h100);
        check("t5_valid", 32'(instr_valid), 32'd0);
        step();
        check("t5_head_pc",  instr_pc,    32'h100);
        check("t5_next_addr", mem_address, 32'h104);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
